os_input_framer: RTL and testbench

Overlap-save input framer placed directly upstream of the FFT/IFFT engine. It accepts a continuous I/Q sample stream and stores it in a circular buffer. It emits NFFT-sample blocks with 50% overlap: the previous HOP samples followed by HOP new samples. The buffer absorbs input that arrives while the FFT is computing or sending and cannot accept data.

---
 rtl/os_input_framer.sv | 84 ++++++++
 tb/tb_os_input_framer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/os_input_framer.sv
// os_input_framer: overlap-save framer that buffers an I/Q stream and emits NFFT-sample blocks with 50% overlap.
// The buffer holds two blocks so that input keeps arriving while the FFT is busy.
module os_input_framer #(
   parameter int NFFT = 32,
   parameter int LOGN = 5,
   parameter int NB   = 9,
   parameter int NBF  = 7
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_valid,
   input  logic [NB-1:0] i_xI,
   input  logic [NB-1:0] i_xQ,
   input  logic          i_ready,
   output logic          o_valid,
   output logic          o_start,
   output logic [NB-1:0] o_xI,
   output logic [NB-1:0] o_xQ,
   output logic          o_overflow
);
   localparam int HOP   = NFFT / 2;
   localparam int DEPTH = 2 * NFFT;
   localparam int AW    = LOGN + 1;
   localparam int FW    = LOGN + 2;

   if (NFFT != (1 << LOGN) || NBF >= NB) begin : g_param_err
      $error("os_input_framer: inconsistent NFFT/LOGN or NBF");
   end

   typedef enum logic {S_IDLE, S_SEND} state_t;

   logic [2*NB-1:0] buf_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_base_q, rd_addr;
   logic [LOGN-1:0] idx_q;
   logic [FW-1:0]   fill_q, fill_d;
   state_t          state_q;
   logic            wr_en, drop, emit, last;

   always_comb begin
      wr_en   = i_valid && (fill_q < FW'(DEPTH));
      drop    = i_valid && !wr_en;
      emit    = (state_q == S_SEND) && i_ready;
      last    = emit && (idx_q == LOGN'(NFFT - 1));
      rd_addr = rd_base_q + AW'(idx_q);
      fill_d  = fill_q + FW'(wr_en) - (last ? FW'(HOP) : '0);
   end

   // Reset starts rd_base one hop behind wr_ptr so the first block's overlap half reads zeros.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
         wr_ptr_q   <= '0;
         rd_base_q  <= AW'(DEPTH - HOP);
         idx_q      <= '0;
         fill_q     <= FW'(HOP);
         state_q    <= S_IDLE;
         o_valid    <= 1'b0;
         o_start    <= 1'b0;
         o_xI       <= '0;
         o_xQ       <= '0;
         o_overflow <= 1'b0;
      end else begin
         if (wr_en) begin
            buf_q[wr_ptr_q] <= {i_xI, i_xQ};
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         fill_q     <= fill_d;
         o_overflow <= drop;
         o_valid    <= emit;
         o_start    <= emit && (idx_q == '0);
         if (emit) begin
            {o_xI, o_xQ} <= buf_q[rd_addr];
            idx_q        <= idx_q + LOGN'(1);
         end
         if (last) rd_base_q <= rd_base_q + AW'(HOP);
         if (state_q == S_IDLE && fill_q >= FW'(NFFT) && i_ready) begin
            state_q <= S_SEND;
            idx_q   <= '0;
         end else if (last) begin
            state_q <= S_IDLE;
         end
      end
   end
endmodule

// File: tb/tb_os_input_framer.sv
// tb_os_input_framer: directed bench for the overlap-save input framer.
module tb_os_input_framer;
   localparam int NFFT = 32;
   localparam int LOGN = 5;
   localparam int NB   = 9;
   localparam int NBF  = 7;
   localparam int HOP  = 16;

   logic          clk = 1'b0;
   logic          rst, valid, ready;
   logic [NB-1:0] xi, xq, oi, oq;
   logic          ov, os, oovf;

   always #5 clk = ~clk;

   os_input_framer #(.NFFT(NFFT), .LOGN(LOGN), .NB(NB), .NBF(NBF)) dut (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_xI(xi), .i_xQ(xq), .i_ready(ready),
      .o_valid(ov), .o_start(os), .o_xI(oi), .o_xQ(oq), .o_overflow(oovf)
   );

   int tests = 0, fails = 0, sn = 0, cyc = 0, ovf_cnt = 0;
   bit stop = 0;
   logic [NB-1:0] cap_i[$], cap_q[$];
   logic          cap_s[$];
   int            cap_c[$];

   always @(negedge clk) begin
      cyc++;
      if (ov === 1'b1) begin
         cap_i.push_back(oi);
         cap_q.push_back(oq);
         cap_s.push_back(os);
         cap_c.push_back(cyc);
      end
      if (oovf === 1'b1) ovf_cnt++;
   end

   // Block k sample j carries input n = k*HOP-HOP+j; negative n is zero fill.
   function automatic logic [NB-1:0] ref_i(input int k, input int j, input int base);
      int n = k * HOP - HOP + j;
      return (n < 0) ? '0 : NB'(base + n + 1);
   endfunction

   task automatic push();
      valid = 1'b1;
      xi = NB'(sn + 1);
      xq = NB'(-(sn + 1));
      sn++;
      @(posedge clk); #1;
      valid = 1'b0;
   endtask

   task automatic wait_valid(input int n, input string name);
      int seen = 0, budget = 0;
      while (seen < n && budget < 500) begin
         @(posedge clk); #1;
         budget++;
         if (ov === 1'b1) seen++;
      end
      tests++;
      if (seen < n) begin
         fails++;
         $display("FAIL %s timeout: saw %0d valid, need %0d", name, seen, n);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; valid = 1'b0; ready = 1'b0; xi = '0; xq = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      sn = 0;
   endtask

   task automatic test_reset();
      do_reset();
      tests++;
      if ({ov, os, oovf, oi, oq} !== '0) begin
         fails++; $display("FAIL reset_outputs got %b want 0", {ov, os, oovf, oi, oq});
      end
      tests++;
      if (dut.fill_q !== 7'd16 || dut.rd_base_q !== 6'd48 || dut.wr_ptr_q !== 6'd0) begin
         fails++; $display("FAIL reset_ptrs fill=%0d rd_base=%0d wr_ptr=%0d want 16/48/0", dut.fill_q, dut.rd_base_q, dut.wr_ptr_q);
      end
      ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (ov !== 1'b0) begin
         fails++; $display("FAIL reset_idle o_valid=%b want 0 with fill 16", ov);
      end
   endtask

   task automatic test_block0();
      int b;
      do_reset();
      ready = 1'b1;
      b = cap_i.size();
      repeat (16) push();
      tests++;
      if (ov !== 1'b0) begin fails++; $display("FAIL b0_lat0 o_valid=%b want 0", ov); end
      @(posedge clk); #1;
      tests++;
      if (ov !== 1'b0) begin fails++; $display("FAIL b0_lat1 o_valid=%b want 0", ov); end
      @(posedge clk); #1;
      tests++;
      if ({ov, os} !== 2'b11) begin fails++; $display("FAIL b0_lat2 valid/start=%b want 11", {ov, os}); end
      wait_valid(31, "b0_wait");
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (cap_i.size() - b !== 32) begin fails++; $display("FAIL b0_count got %0d want 32", cap_i.size() - b); end
      for (int j = 0; j < 32 && b + j < cap_i.size(); j++) begin
         logic [NB-1:0] e;
         e = ref_i(0, j, 0);
         tests++;
         if (cap_i[b+j] !== e || cap_q[b+j] !== NB'(-e) || cap_s[b+j] !== (j == 0)) begin
            fails++;
            $display("FAIL b0_sample[%0d] got I=%0d Q=%0d s=%b want I=%0d Q=%0d s=%b", j, cap_i[b+j], cap_q[b+j], cap_s[b+j], e, NB'(-e), j == 0);
         end
      end
      tests++;
      if (cap_c.size() >= b + 32 && cap_c[b+31] - cap_c[b] !== 31) begin
         fails++; $display("FAIL b0_contig span=%0d want 31", cap_c[b+31] - cap_c[b]);
      end
   endtask

   task automatic test_continuous();
      int b, o0;
      do_reset();
      ready = 1'b1;
      b = cap_i.size();
      o0 = ovf_cnt;
      fork
         repeat (48) push();
         for (int k = 0; k < 3; k++) begin
            wait_valid(32, "cont_wait");
            ready = 1'b0;
            repeat (70) @(posedge clk);
            #1 ready = 1'b1;
         end
      join
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (cap_i.size() - b !== 96) begin fails++; $display("FAIL cont_count got %0d want 96", cap_i.size() - b); end
      for (int j = 0; j < 96 && b + j < cap_i.size(); j++) begin
         logic [NB-1:0] e;
         e = ref_i(j / 32, j % 32, 0);
         tests++;
         if (cap_i[b+j] !== e || cap_q[b+j] !== NB'(-e) || cap_s[b+j] !== (j % 32 == 0)) begin
            fails++;
            $display("FAIL cont_sample[%0d] got I=%0d Q=%0d s=%b want I=%0d Q=%0d", j, cap_i[b+j], cap_q[b+j], cap_s[b+j], e, NB'(-e));
         end
      end
      for (int k = 0; k < 3; k++) begin
         tests++;
         if (cap_c.size() >= b + 32*k + 32 && cap_c[b+32*k+31] - cap_c[b+32*k] !== 31) begin
            fails++; $display("FAIL cont_contig blk%0d span=%0d want 31", k, cap_c[b+32*k+31] - cap_c[b+32*k]);
         end
      end
      tests++;
      if (ovf_cnt !== o0) begin fails++; $display("FAIL cont_ovf got %0d pulses want 0", ovf_cnt - o0); end
   endtask

   task automatic test_overflow();
      int b, o0;
      do_reset();
      b = cap_i.size();
      o0 = ovf_cnt;
      repeat (48) push();
      tests++;
      if (dut.fill_q !== 7'd64 || oovf !== 1'b0) begin
         fails++; $display("FAIL ovf_full fill=%0d ovf=%b want 64/0", dut.fill_q, oovf);
      end
      push();
      tests++;
      if (oovf !== 1'b1 || dut.wr_ptr_q !== 6'd48 || dut.fill_q !== 7'd64) begin
         fails++; $display("FAIL ovf_drop ovf=%b wr_ptr=%0d fill=%0d want 1/48/64", oovf, dut.wr_ptr_q, dut.fill_q);
      end
      @(posedge clk); #1;
      tests++;
      if (oovf !== 1'b0 || ovf_cnt - o0 !== 1) begin
         fails++; $display("FAIL ovf_pulse ovf=%b pulses=%0d want 0/1", oovf, ovf_cnt - o0);
      end
      ready = 1'b1;
      wait_valid(96, "ovf_wait");
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (cap_i.size() - b !== 96 || dut.fill_q !== 7'd16) begin
         fails++; $display("FAIL ovf_drain count=%0d fill=%0d want 96/16", cap_i.size() - b, dut.fill_q);
      end
      for (int j = 0; j < 96 && b + j < cap_i.size(); j++) begin
         logic [NB-1:0] e;
         e = ref_i(j / 32, j % 32, 0);
         tests++;
         if (cap_i[b+j] !== e || cap_q[b+j] !== NB'(-e)) begin
            fails++; $display("FAIL ovf_sample[%0d] got I=%0d Q=%0d want I=%0d Q=%0d", j, cap_i[b+j], cap_q[b+j], e, NB'(-e));
         end
      end
   endtask

   task automatic test_pause();
      int b;
      do_reset();
      ready = 1'b1;
      b = cap_i.size();
      repeat (16) push();
      wait_valid(10, "pause_wait");
      ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         tests++;
         if (ov !== 1'b0 || dut.idx_q !== 5'd10) begin
            fails++; $display("FAIL pause_hold[%0d] o_valid=%b idx=%0d want 0/10", c, ov, dut.idx_q);
         end
      end
      ready = 1'b1;
      wait_valid(22, "pause_resume");
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (cap_i.size() - b !== 32) begin fails++; $display("FAIL pause_count got %0d want 32", cap_i.size() - b); end
      tests++;
      if (cap_c.size() >= b + 11 && cap_c[b+10] - cap_c[b+9] !== 4) begin
         fails++; $display("FAIL pause_gap got %0d want 4", cap_c[b+10] - cap_c[b+9]);
      end
      for (int j = 0; j < 32 && b + j < cap_i.size(); j++) begin
         logic [NB-1:0] e;
         e = ref_i(0, j, 0);
         tests++;
         if (cap_i[b+j] !== e || cap_q[b+j] !== NB'(-e) || cap_s[b+j] !== (j == 0)) begin
            fails++; $display("FAIL pause_sample[%0d] got I=%0d s=%b want I=%0d s=%b", j, cap_i[b+j], cap_s[b+j], e, j == 0);
         end
      end
   endtask

   task automatic test_last_write();
      int b;
      do_reset();
      ready = 1'b1;
      repeat (16) push();
      wait_valid(31, "lastw_wait");
      push();
      tests++;
      if (dut.fill_q !== 7'd17 || ov !== 1'b1 || oi !== 9'd16) begin
         fails++; $display("FAIL lastw_fill fill=%0d valid=%b I=%0d want 17/1/16", dut.fill_q, ov, oi);
      end
      b = cap_i.size() + 1;
      repeat (14) push();
      @(posedge clk); #1;
      tests++;
      if (dut.fill_q !== 7'd31 || ov !== 1'b0) begin
         fails++; $display("FAIL lastw_wait31 fill=%0d valid=%b want 31/0", dut.fill_q, ov);
      end
      push();
      @(posedge clk); #1;
      tests++;
      if (ov !== 1'b0) begin fails++; $display("FAIL lastw_transition o_valid=%b want 0", ov); end
      @(posedge clk); #1;
      tests++;
      if ({ov, os} !== 2'b11 || oi !== 9'd1) begin
         fails++; $display("FAIL lastw_start valid/start=%b I=%0d want 11/1", {ov, os}, oi);
      end
      wait_valid(31, "lastw_blk1");
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (cap_i.size() - b !== 32) begin fails++; $display("FAIL lastw_count got %0d want 32", cap_i.size() - b); end
      for (int j = 0; j < 32 && b + j < cap_i.size(); j++) begin
         logic [NB-1:0] e;
         e = ref_i(1, j, 0);
         tests++;
         if (cap_i[b+j] !== e || cap_q[b+j] !== NB'(-e)) begin
            fails++; $display("FAIL lastw_sample[%0d] got I=%0d Q=%0d want I=%0d Q=%0d", j, cap_i[b+j], cap_q[b+j], e, NB'(-e));
         end
      end
   endtask

   task automatic test_mid_reset();
      int b;
      do_reset();
      ready = 1'b1;
      stop = 0;
      fork
         begin
            int n = 0;
            while (!stop && n < 64) begin push(); n++; end
         end
         begin
            wait_valid(53, "mrst_wait");
            stop = 1;
            rst = 1'b1;
            #1;
            tests++;
            if ({ov, os, oovf, oi, oq} !== '0) begin
               fails++; $display("FAIL mrst_async outputs=%b want 0", {ov, os, oovf, oi, oq});
            end
         end
      join
      @(posedge clk);
      #1 rst = 1'b0;
      tests++;
      if (dut.fill_q !== 7'd16 || dut.wr_ptr_q !== 6'd0) begin
         fails++; $display("FAIL mrst_ptrs fill=%0d wr_ptr=%0d want 16/0", dut.fill_q, dut.wr_ptr_q);
      end
      sn = 100;
      b = cap_i.size();
      repeat (16) push();
      wait_valid(32, "mrst_blk");
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (cap_i.size() - b !== 32) begin fails++; $display("FAIL mrst_count got %0d want 32", cap_i.size() - b); end
      for (int j = 0; j < 32 && b + j < cap_i.size(); j++) begin
         logic [NB-1:0] e;
         e = ref_i(0, j, 100);
         tests++;
         if (cap_i[b+j] !== e || cap_q[b+j] !== NB'(-e) || cap_s[b+j] !== (j == 0)) begin
            fails++; $display("FAIL mrst_sample[%0d] got I=%0d Q=%0d want I=%0d Q=%0d", j, cap_i[b+j], cap_q[b+j], e, NB'(-e));
         end
      end
   endtask

   initial begin
      test_reset();
      test_block0();
      test_continuous();
      test_overflow();
      test_pause();
      test_last_write();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
